// File: rtl/zircon_avalon_ps2_mouse_event_regs.sv
`default_nettype none
// ============================================================================
// Module      : zircon_avalon_ps2_mouse_event_regs
// Description : Avalon-MM register file for the PS/2 mouse core. Decoded
//               mouse packets are queued in a small FIFO so software polling
//               does not lose movement between reads. Exposes DATA (pop),
//               STATUS, CONTROL and CLEAR registers plus a level interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   csi_clk        system clock, rising edge
//   rsi_reset_n    asynchronous active-low reset
//   avs_address    word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 CLEAR
//   avs_read       read request (data returned one cycle later)
//   avs_write      write request
//   avs_writedata  write data
//   avs_readdata   registered read data, zero on cycles after no read
//   ins_irq        registered level interrupt
//   pkt_valid      one-cycle strobe from the packet decoder
//   left_button / right_button / middle_button   button states
//   x_increment / y_increment                    two's complement movement
// ============================================================================
module zircon_avalon_ps2_mouse_event_regs #(
  parameter int INC_W      = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              ins_irq,
  input  logic              pkt_valid,
  input  logic              left_button,
  input  logic              right_button,
  input  logic              middle_button,
  input  logic [INC_W-1:0]  x_increment,
  input  logic [INC_W-1:0]  y_increment
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + 2 * INC_W;
  localparam int CW = AW + 1;   // count must also represent FIFO_DEPTH itself
  localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;
  logic          r_irq_en;
  logic [31:0]   r_readdata;
  logic          r_irq;

  logic          w_empty;
  logic          w_full;
  logic [EW-1:0] w_entry;
  logic          w_rd_data;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_flush;
  logic          w_clear;
  logic          w_ctrl_wr;
  logic [7:0]    w_count8;
  logic [31:0]   w_rdata_next;
  logic          w_unused;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_entry   = {left_button, right_button, middle_button, y_increment, x_increment};
  assign w_rd_data = avs_read & (avs_address == 2'd0);
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_ctrl_wr = avs_write & (avs_address == 2'd2);
  assign w_flush   = w_ctrl_wr & avs_writedata[1];
  assign w_clear   = avs_write & (avs_address == 2'd3) & avs_writedata[0];
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  // A flush discards any same-cycle packet without counting it as a drop.
  assign w_push    = pkt_valid & ~w_flush & (~w_full | w_pop);
  assign w_drop    = pkt_valid & ~w_flush & w_full & ~w_pop;
  // STATUS count field is 8 bits; only a 256-deep FIFO when full exceeds it,
  // and that case is still visible through the full flag.
  assign w_count8  = 8'(r_count);
  assign w_unused  = ^avs_writedata[31:2];

  always_comb begin
    w_rdata_next = '0;
    if (avs_read) begin
      case (avs_address)
        2'd0: if (!w_empty) w_rdata_next = 32'h8000_0000 | 32'(r_mem[r_head]);
        2'd1: w_rdata_next = {8'd0, r_drop_cnt, w_count8, 5'd0, r_overflow, w_full, w_empty};
        2'd2: w_rdata_next = {31'd0, r_irq_en};
        default: w_rdata_next = '0;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge csi_clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_irq_en   <= 1'b0;
      r_readdata <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rdata_next;

      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

      // Clear beats a same-cycle drop: the drop is neither flagged nor counted.
      if (w_clear) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 8'd0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      if (w_ctrl_wr) r_irq_en <= avs_writedata[0];

      r_irq <= r_irq_en & (~w_empty | r_overflow);
    end
  end

  assign avs_readdata = r_readdata;
  assign ins_irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_zircon_avalon_ps2_mouse_event_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_zircon_avalon_ps2_mouse_event_regs
// Description : Scoreboard bench. A driver issues one bus/packet cycle per
//               clock and pushes the expected read data and interrupt level
//               from a queue-based reference model; a monitor pops and
//               compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zircon_avalon_ps2_mouse_event_regs;

  localparam int INC_W = 9;
  localparam int DEPTH = 8;
  localparam int EW    = 3 + 2 * INC_W;

  logic             csi_clk = 1'b0;
  logic             rsi_reset_n = 1'b0;
  logic [1:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic [31:0]      avs_readdata;
  logic             ins_irq;
  logic             pkt_valid = 1'b0;
  logic             left_button = 1'b0;
  logic             right_button = 1'b0;
  logic             middle_button = 1'b0;
  logic [INC_W-1:0] x_increment = '0;
  logic [INC_W-1:0] y_increment = '0;

  zircon_avalon_ps2_mouse_event_regs #(.INC_W(INC_W), .FIFO_DEPTH(DEPTH)) dut (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .ins_irq(ins_irq),
    .pkt_valid(pkt_valid), .left_button(left_button), .right_button(right_button),
    .middle_button(middle_button), .x_increment(x_increment), .y_increment(y_increment)
  );

  always #5 csi_clk = ~csi_clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t          exp_q[$];
  logic [EW-1:0] mq[$];        // reference packet queue
  logic          m_ovf = 1'b0;
  logic [7:0]    m_dc = 8'd0;
  logic          m_irq_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {8'd0, m_dc, c, 5'd0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  function automatic logic [EW-1:0] mk(bit l, bit r, bit m, int y, int x);
    logic [INC_W-1:0] yy;
    logic [INC_W-1:0] xx;
    yy = INC_W'(y);
    xx = INC_W'(x);
    return {l, r, m, yy, xx};
  endfunction

  // Monitor: every driven cycle produced exactly one expectation.
  exp_t mon_e;
  always @(posedge csi_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("readdata", avs_readdata, mon_e.rd);
      check("ins_irq", 32'(ins_irq), 32'(mon_e.irq));
    end
  end

  // One bus/packet cycle: drive inputs, predict, update the model.
  task automatic cycle(bit rd, bit [1:0] addr, bit wr, bit [31:0] wd, bit pv, logic [EW-1:0] ent);
    exp_t e;
    bit   pop, flush, clr, full, drop;
    @(negedge csi_clk);
    avs_read = rd; avs_address = addr; avs_write = wr; avs_writedata = wd;
    pkt_valid = pv;
    {left_button, right_button, middle_button, y_increment, x_increment} = ent;

    e.irq = m_irq_en && ((mq.size() != 0) || m_ovf);
    e.rd  = 32'd0;
    if (rd) begin
      case (addr)
        2'd0: if (mq.size() > 0) e.rd = 32'h8000_0000 | 32'(mq[0]);
        2'd1: e.rd = m_status();
        2'd2: e.rd = {31'd0, m_irq_en};
        default: e.rd = 32'd0;
      endcase
    end
    exp_q.push_back(e);

    pop   = rd && (addr == 2'd0) && (mq.size() > 0);
    flush = wr && (addr == 2'd2) && wd[1];
    clr   = wr && (addr == 2'd3) && wd[0];
    full  = (mq.size() == DEPTH);
    drop  = 1'b0;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (pv) begin
        if (!full || pop) mq.push_back(ent);
        else drop = 1'b1;
      end
    end
    if (clr) begin m_ovf = 1'b0; m_dc = 8'd0; end
    else if (drop) begin m_ovf = 1'b1; if (m_dc != 8'hFF) m_dc++; end
    if (wr && addr == 2'd2) m_irq_en = wd[0];
  endtask

  task automatic idle();                 cycle(0, 0, 0, 0, 0, '0);  endtask
  task automatic rd(bit [1:0] a);        cycle(1, a, 0, 0, 0, '0);  endtask
  task automatic wr(bit [1:0] a, bit [31:0] d); cycle(0, a, 1, d, 0, '0); endtask
  task automatic push(logic [EW-1:0] e); cycle(0, 0, 0, 0, 1, e);   endtask

  // Reset pulse landing between a read request and the edge that would serve it.
  task automatic mid_reset();
    @(negedge csi_clk);
    avs_read = 1'b1; avs_address = 2'd0; avs_write = 1'b0; pkt_valid = 1'b0;
    #2 rsi_reset_n = 1'b0;
    #1;
    check("async_rst_readdata", avs_readdata, 32'd0);
    check("async_rst_irq", 32'(ins_irq), 32'd0);
    mq.delete(); m_ovf = 1'b0; m_dc = 8'd0; m_irq_en = 1'b0;
    @(negedge csi_clk);
    avs_read = 1'b0;
    rsi_reset_n = 1'b1;
    #1;
    check("post_rst_readdata", avs_readdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge csi_clk);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_irq", 32'(ins_irq), 32'd0);
    rsi_reset_n = 1'b1;

    // Reset state through the bus
    rd(1); rd(0); idle();

    // Single packet with interrupt enabled
    wr(2, 32'h1);
    push(mk(1, 0, 0, 9'h1FF, 9'h005));
    idle(); idle();
    rd(0); rd(1); idle(); idle();

    // Overflow: ten packets into eight slots
    for (int i = 1; i <= 10; i++) push(mk(0, 0, 0, 0, i));
    rd(1);
    for (int i = 0; i < 9; i++) rd(0);
    rd(1); idle();

    // Full FIFO: push coincident with a DATA read is accepted
    for (int i = 1; i <= DEPTH; i++) push(mk(0, 1, 0, -i, i));
    cycle(1, 0, 0, 0, 1, mk(1, 1, 1, 9'h0AA, 9'h155));
    rd(1);
    for (int i = 0; i < DEPTH; i++) rd(0);
    rd(1);

    // Clear and flush
    for (int i = 1; i <= 9; i++) push(mk(0, 0, 1, i, i));
    rd(1);
    wr(3, 32'h1);
    rd(1);
    for (int i = 0; i < DEPTH; i++) rd(0);
    for (int i = 1; i <= 5; i++) push(mk(1, 0, 0, i, -i));
    wr(2, 32'h3);
    rd(1); rd(2); idle();

    // Asynchronous reset mid-burst with four entries queued
    for (int i = 1; i <= 4; i++) push(mk(0, 1, 1, i, i));
    idle();
    rd(1);
    mid_reset();
    rd(1); idle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit        r, w, p;
      bit [1:0]  a;
      bit [31:0] d;
      r = ($urandom_range(0, 2) == 0);
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 9) == 0);
      d = $urandom;
      if (w && a == 2'd2 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      p = ($urandom_range(0, 1) == 0);
      cycle(r, a, w, d, p, EW'($urandom));
    end
    idle(); idle();
    @(negedge csi_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
